// File: rtl/wav_recorder.sv
// PWM audio recorder: integrates a 1-bit duty-cycle stream over 256-tick frames
// and stores one saturated 8-bit sample per frame in an inferred block RAM.
module wav_recorder #(
    parameter int MEM_SIZE = 16384,
    parameter int PRESCALE = 25
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          audio_in,
    input  logic                          start_rec,
    input  logic                          stop_rec,
    input  logic [$clog2(MEM_SIZE)-1:0]   rd_addr,
    output logic [7:0]                    rd_data,
    output logic                          recording,
    output logic                          done,
    output logic [$clog2(MEM_SIZE):0]     sample_count
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(PRESCALE);
    localparam logic [AW:0]   LAST_COUNT = (AW+1)'(MEM_SIZE - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        RECORD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      phase_q, phase_d;
    logic [8:0]      ones_q, ones_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW:0]     count_q, count_d;
    logic            done_q, done_d;

    logic            start_ok;
    logic            tick;
    logic            frame_end;
    logic            last_write;
    logic [8:0]      ones_sum;
    logic [7:0]      wr_data;

    logic [7:0]      mem [MEM_SIZE];
    logic [7:0]      rd_data_q;

    assign start_ok   = start_rec && !stop_rec;
    assign tick       = (state_q == RECORD) && (presc_q == PRESC_MAX);
    assign frame_end  = tick && (phase_q == 8'hFF);
    assign last_write = frame_end && (count_q == LAST_COUNT);
    // ones can reach 256 only when every tick of the frame was high
    assign ones_sum   = ones_q + {8'd0, sync2_q};
    assign wr_data    = ones_sum[8] ? 8'hFF : ones_sum[7:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            presc_q <= '0;
            phase_q <= '0;
            ones_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= audio_in;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            phase_q <= phase_d;
            ones_q  <= ones_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RECORD;
            RECORD:  if (last_write || stop_rec) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        ones_d  = ones_q;
        addr_d  = addr_q;
        count_d = count_q;
        done_d  = last_write;
        if (state_q == IDLE) begin
            if (start_ok) begin
                presc_d = '0;
                phase_d = '0;
                ones_d  = '0;
                addr_d  = '0;
                count_d = '0;
            end
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (frame_end) begin
                ones_d  = '0;
                phase_d = '0;
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
            end else if (tick) begin
                ones_d  = ones_sum;
                phase_d = phase_q + 8'd1;
            end
        end
    end

    // Sample RAM: read-before-write on a shared address returns the old byte
    always_ff @(posedge CLK) begin
        if (frame_end) begin
            mem[addr_q] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data      = rd_data_q;
    assign recording    = (state_q == RECORD);
    assign done         = done_q;
    assign sample_count = count_q;
endmodule
